multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the CPCPU datapath. It replaces the single-cycle decode path with a five-state FSM (IF/ID/EXE/MEM/WB), so one ALU and one shared instruction/data memory port serve every instruction. It issues per-state strobes to the PC, IR, register file and memory, and waits on a memory ready handshake. A watchdog and a trap state catch illegal opcodes and stalled memory.

## Interface
- MEM_TIMEOUT, default 15: maximum wait cycles for `mem_ready` in IF/MEM before trapping; 0 disables the watchdog.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26], stable from ID until return to IF.
- func  in  6  IR function field; only func[2:0] is decoded, func[5:3] ignored.
- z  in  1  ALU zero flag, combinational in EXE.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- wmem  out  1  memory write strobe.
- irwrite  out  1  IR load strobe.
- pcwrite  out  1  PC load strobe.
- pcsource  out  2  PC next select: 00 = pc+4, 01 = branch target, 10 = jump target.
- wreg  out  1  register-file write strobe.
- regrt  out  1  destination select: 1 = rt, 0 = rd.
- m2reg  out  1  write-back select: 1 = memory data, 0 = ALU result.
- aluc  out  3  ALU op: 000 add, 001 and, 010 or, 011 xor, 100 srl, 101 sll, 110 sub/compare.
- aluimm  out  1  ALU B operand = extended immediate.
- sext  out  1  sign-extend (1) or zero-extend (0) the immediate.
- shift  out  1  ALU A operand = shift-amount field.
- state  out  3  IF=000, ID=001, EXE=010, MEM=011, WB=100, TRAP=111.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  high while in TRAP.

## Operation
- Decode table (op / func[2:0]):
  - add 000000/001; and 000001/001; or 000001/010; xor 000001/100.
  - srl 000010/010; sll 000010/011.
  - addi 000101; andi 001001; ori 001010; xori 001100.
  - lw 001101; sw 001110; beq 001111; bne 010000; j 010010.
  - Any other combination is illegal.
- Level controls (`aluc`, `regrt`, `aluimm`, `sext`, `shift`, `m2reg`) are decoded from op/func and driven in ID, EXE, MEM and WB. They are 0 in IF and TRAP.
  - `sext` = addi, lw, sw, beq, bne.
  - `aluimm` = I-type ALU ops, lw, sw.
  - `shift` = srl, sll.
  - `regrt` = I-type ALU ops, lw.
- IF:
  - Drives `mem_req`=1, `iord`=0.
  - On `mem_ready`: `irwrite`=1, `pcwrite`=1, `pcsource`=00, then go to ID. Otherwise stay in IF.
- ID:
  - Illegal instruction → TRAP.
  - j: `pcwrite`=1, `pcsource`=10, `retire`=1, then go to IF.
  - All other instructions → EXE.
- EXE:
  - beq: `pcwrite`=z. bne: `pcwrite`=!z. Both drive `pcsource`=01 and `retire`=1, then go to IF.
  - lw/sw → MEM.
  - ALU ops → WB.
- MEM:
  - Drives `mem_req`=1, `iord`=1, and `wmem`=1 for sw (held for the whole wait).
  - On `mem_ready`: lw → WB; sw → IF with `retire`=1.
  - Otherwise stay in MEM.
- WB: `wreg`=1 for exactly one cycle, `m2reg`=lw, `retire`=1, then go to IF.
- TRAP: all strobes 0, `illegal`=1. Exit only via `rst`.
- Watchdog:
  - A wait counter clears on entry to IF/MEM and increments each cycle `mem_ready`=0.
  - Reaching MEM_TIMEOUT → TRAP; no `wmem` in the trap cycle.
  - Counter width is ceil(log2(MEM_TIMEOUT+1)), saturating.

## Timing
- Reset:
  - While `rst`=1: state=IF, wait counter=0, and every output is 0, including `mem_req` and `state`=000.
  - The first fetch request appears in the first cycle after `rst` falls.
- Strobes are Mealy, combinational from state, op, func, z and mem_ready. `pcwrite`, `irwrite` and `wreg` assert only in the cycle where the transition happens.
- Cycles per instruction with zero-wait memory: j 2; beq/bne 3; sw 4; ALU ops 4; lw 5. Each wait cycle adds 1.
- A `mem_ready` asserted outside IF/MEM is ignored.
- Reset asserted mid-instruction: state returns to IF immediately (asynchronously). The aborted instruction produces no further `wreg`/`wmem`/`pcwrite`/`retire`.
- `retire` never asserts together with an entry to TRAP.

## Test plan
- **Reset:** reset 3 cycles, release with `mem_ready`=1, op=000000, func=001 (add). Required: IF, ID, EXE, WB, with `wreg`=1, `regrt`=0, `aluc`=000 in WB; `retire` in cycle 4.
- **Branches:** beq with z=1, then z=0. Required: EXE `pcwrite`=1 then 0, `pcsource`=01, `sext`=1, `aluc`=110. Repeat bne with the result inverted.
- **Load wait states:** lw with `mem_ready` low for 3 cycles in MEM. Required: `mem_req`=1 and `iord`=1 held; WB has `m2reg`=1, `regrt`=1; 8 cycles total.
- **Store and jump:** sw gives `wmem`=1 only in MEM and no `wreg`. j (op 010010) gives `pcwrite`=1, `pcsource`=10 in ID.
- **Illegal decode:** op=000001 with func=111, and op=111111. Required: TRAP, `illegal`=1, `state`=111, and it stays there until `rst`.
- **Watchdog and reset abort:** hold `mem_ready`=0 in IF for 15 cycles → TRAP. Assert `rst` in the middle of a lw MEM wait → no `wreg` follows, and fetch restarts.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between multicycle_ctrl and the CPCPU datapath/memory.
// master: controller (decode inputs in, strobes out); slave: datapath side.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       wmem;
  logic       irwrite;
  logic       pcwrite;
  logic [1:0] pcsource;
  logic       wreg;
  logic       regrt;
  logic       m2reg;
  logic [2:0] aluc;
  logic       aluimm;
  logic       sext;
  logic       shift;
  logic [2:0] state;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, func, z, mem_ready,
    output mem_req, iord, wmem, irwrite, pcwrite, pcsource,
    output wreg, regrt, m2reg, aluc, aluimm, sext, shift,
    output state, retire, illegal
  );

  modport slave (
    output op, func, z, mem_ready,
    input  mem_req, iord, wmem, irwrite, pcwrite, pcsource,
    input  wreg, regrt, m2reg, aluc, aluimm, sext, shift,
    input  state, retire, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer with memory watchdog and trap state.
// Ports: clk, rst (async high), bus (master: op/func/z/mem_ready in, strobes out).
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST =
    (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;
  localparam bit WD_ON = (MEM_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b111
  } state_t;

  state_t        st;
  state_t        nxt;
  logic [CW-1:0] cnt;

  logic [5:0] op;
  logic [2:0] fn;
  logic       unused_func;

  assign op          = bus.op;
  assign fn          = bus.func[2:0];
  assign unused_func = ^bus.func[5:3];

  logic i_add, i_and, i_or, i_xor, i_srl, i_sll;
  logic i_addi, i_andi, i_ori, i_xori;
  logic i_lw, i_sw, i_beq, i_bne, i_j;
  logic i_ialu, i_legal;

  assign i_add  = (op == 6'b000000) && (fn == 3'b001);
  assign i_and  = (op == 6'b000001) && (fn == 3'b001);
  assign i_or   = (op == 6'b000001) && (fn == 3'b010);
  assign i_xor  = (op == 6'b000001) && (fn == 3'b100);
  assign i_srl  = (op == 6'b000010) && (fn == 3'b010);
  assign i_sll  = (op == 6'b000010) && (fn == 3'b011);
  assign i_addi = (op == 6'b000101);
  assign i_andi = (op == 6'b001001);
  assign i_ori  = (op == 6'b001010);
  assign i_xori = (op == 6'b001100);
  assign i_lw   = (op == 6'b001101);
  assign i_sw   = (op == 6'b001110);
  assign i_beq  = (op == 6'b001111);
  assign i_bne  = (op == 6'b010000);
  assign i_j    = (op == 6'b010010);

  assign i_ialu  = i_addi | i_andi | i_ori | i_xori;
  assign i_legal = i_add | i_and | i_or | i_xor
                 | i_srl | i_sll | i_ialu
                 | i_lw | i_sw | i_beq | i_bne | i_j;

  logic [2:0] aluc_d;

  always_comb begin
    aluc_d = 3'b000;
    unique case (1'b1)
      i_and | i_andi: aluc_d = 3'b001;
      i_or  | i_ori:  aluc_d = 3'b010;
      i_xor | i_xori: aluc_d = 3'b011;
      i_srl:          aluc_d = 3'b100;
      i_sll:          aluc_d = 3'b101;
      i_beq | i_bne:  aluc_d = 3'b110;
      default:        aluc_d = 3'b000;
    endcase
  end

  // A wait cycle is one spent in IF/MEM without mem_ready.
  // The last permitted wait cycle traps instead of waiting.
  logic waiting;
  logic tmo;

  assign waiting = ((st == S_IF) || (st == S_MEM))
                 && !bus.mem_ready;
  assign tmo     = WD_ON && waiting && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= S_IF;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (nxt != st)
        cnt <= '0;
      else if (waiting && (cnt != CNT_MAX))
        cnt <= cnt + CW'(1);
    end
  end

  assign bus.state = st;

  always_comb begin
    nxt          = st;
    bus.mem_req  = 1'b0;
    bus.iord     = 1'b0;
    bus.wmem     = 1'b0;
    bus.irwrite  = 1'b0;
    bus.pcwrite  = 1'b0;
    bus.pcsource = 2'b00;
    bus.wreg     = 1'b0;
    bus.retire   = 1'b0;
    bus.illegal  = 1'b0;
    bus.aluc     = 3'b000;
    bus.regrt    = 1'b0;
    bus.aluimm   = 1'b0;
    bus.sext     = 1'b0;
    bus.shift    = 1'b0;
    bus.m2reg    = 1'b0;

    if ((st != S_IF) && (st != S_TRAP)) begin
      bus.aluc   = aluc_d;
      bus.regrt  = i_ialu | i_lw;
      bus.aluimm = i_ialu | i_lw | i_sw;
      bus.sext   = i_addi | i_lw | i_sw | i_beq | i_bne;
      bus.shift  = i_srl | i_sll;
      bus.m2reg  = i_lw;
    end

    case (st)
      S_IF: begin
        bus.mem_req = 1'b1;
        if (tmo) begin
          nxt = S_TRAP;
        end else if (bus.mem_ready) begin
          bus.irwrite = 1'b1;
          bus.pcwrite = 1'b1;
          nxt         = S_ID;
        end
      end
      S_ID: begin
        if (!i_legal) begin
          nxt = S_TRAP;
        end else if (i_j) begin
          bus.pcwrite  = 1'b1;
          bus.pcsource = 2'b10;
          bus.retire   = 1'b1;
          nxt          = S_IF;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (i_beq | i_bne) begin
          bus.pcwrite  = i_beq ? bus.z : !bus.z;
          bus.pcsource = 2'b01;
          bus.retire   = 1'b1;
          nxt          = S_IF;
        end else if (i_lw | i_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (tmo) begin
          nxt = S_TRAP;
        end else begin
          bus.wmem = i_sw;
          if (bus.mem_ready) begin
            if (i_lw) begin
              nxt = S_WB;
            end else begin
              bus.retire = 1'b1;
              nxt        = S_IF;
            end
          end
        end
      end
      S_WB: begin
        bus.wreg   = 1'b1;
        bus.retire = 1'b1;
        nxt        = S_IF;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
      end
      default: begin
        nxt = S_TRAP;
      end
    endcase

    // Reset silences every output, including the IF fetch request.
    if (rst) begin
      bus.mem_req  = 1'b0;
      bus.iord     = 1'b0;
      bus.wmem     = 1'b0;
      bus.irwrite  = 1'b0;
      bus.pcwrite  = 1'b0;
      bus.pcsource = 2'b00;
      bus.wreg     = 1'b0;
      bus.retire   = 1'b0;
      bus.illegal  = 1'b0;
      bus.aluc     = 3'b000;
      bus.regrt    = 1'b0;
      bus.aluimm   = 1'b0;
      bus.sext     = 1'b0;
      bus.shift    = 1'b0;
      bus.m2reg    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl with a CPI/strobe-count reference.
// Drives op/func/z/mem_ready through the slave side of the bundle.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instruction table: 0 add,1 and,2 or,3 xor,4 srl,5 sll,
  // 6 addi,7 andi,8 ori,9 xori,10 lw,11 sw,12 beq,13 bne,14 j
  localparam int LW  = 10;
  localparam int SW  = 11;
  localparam int BEQ = 12;
  localparam int BNE = 13;
  localparam int JMP = 14;

  logic [5:0] OPS [15] = '{
    6'd0, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2,
    6'd5, 6'd9, 6'd10, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd16, 6'd18};
  logic [2:0] FN [15] = '{
    3'd1, 3'd1, 3'd2, 3'd4, 3'd2, 3'd3,
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [2:0] ALUC [15] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0};

  function automatic bit is_ialu(int k);
    return (k >= 6) && (k <= 9);
  endfunction

  function automatic int cpi(int k);
    if (k == JMP) return 2;
    if (k == BEQ || k == BNE) return 3;
    if (k == LW) return 5;
    return 4;
  endfunction

  function automatic int legal_ref(logic [5:0] o, logic [5:0] f);
    for (int k = 0; k < 15; k++) begin
      if (OPS[k] == o) begin
        if (k > 5) return k;
        if (f[2:0] == FN[k]) return k;
      end
    end
    return -1;
  endfunction

  function automatic logic [20:0] outs();
    return {bus.mem_req, bus.iord, bus.wmem, bus.irwrite,
            bus.pcwrite, bus.pcsource, bus.wreg, bus.regrt,
            bus.m2reg, bus.aluc, bus.aluimm, bus.sext,
            bus.shift, bus.state, bus.retire, bus.illegal};
  endfunction

  function automatic logic [8:0] levels();
    return {bus.aluc, bus.regrt, bus.aluimm,
            bus.sext, bus.shift, bus.m2reg};
  endfunction

  // Tasks start and end just after a falling edge.
  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_instr(input int k, input logic zin,
                           input int ifw, input int mw);
    int ifc, mc, ncyc, wreg_n, wmem_n, pcw_n, iord_n;
    int exp_cyc, exp_pcw, exp_mem;
    logic [8:0] exp_lv;
    logic [4:0] wb_got, wb_exp;
    logic exp_regrt;
    bit done;
    ifc = 0; mc = 0; ncyc = 0; done = 0;
    wreg_n = 0; wmem_n = 0; pcw_n = 0; iord_n = 0;
    wb_got = '0;
    bus.op   = OPS[k];
    bus.func = (k <= 5) ? {3'($urandom), FN[k]} : 6'($urandom);
    bus.z    = zin;
    exp_regrt = is_ialu(k) || k == LW;
    exp_lv = {ALUC[k], exp_regrt,
              is_ialu(k) || k == LW || k == SW,
              k == 6 || k == LW || k == SW || k == BEQ || k == BNE,
              k == 4 || k == 5, k == LW};
    exp_mem = (k == LW || k == SW) ? mw + 1 : 0;
    exp_cyc = cpi(k) + ifw + ((k == LW || k == SW) ? mw : 0);
    exp_pcw = 1 + (k == JMP ? 1 : 0)
                + ((k == BEQ && zin) ? 1 : 0)
                + ((k == BNE && !zin) ? 1 : 0);
    wb_exp = {ALUC[k], exp_regrt, k == LW};
    for (int c = 0; c < 80 && !done; c++) begin
      if (bus.mem_req && !bus.iord) begin
        bus.mem_ready = (ifc >= ifw); ifc++;
      end else if (bus.mem_req) begin
        bus.mem_ready = (mc >= mw); mc++;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      #1;
      if (c == 0) begin
        n_checks++;
        if ({bus.state, bus.mem_req, bus.iord, levels()}
            !== {3'b000, 1'b1, 1'b0, 9'd0}) begin
          n_errors++;
          $display("FAIL if_ctl k=%0d: got %h expected %h", k,
            {bus.state, bus.mem_req, bus.iord, levels()},
            {3'b000, 1'b1, 1'b0, 9'd0});
        end
      end
      if (c == ifw + 1) begin
        n_checks++;
        if ({bus.state, levels()} !== {3'b001, exp_lv}) begin
          n_errors++;
          $display("FAIL id_ctl k=%0d: got %h expected %h", k,
            {bus.state, levels()}, {3'b001, exp_lv});
        end
        if (k == JMP) begin
          n_checks++;
          if ({bus.pcwrite, bus.pcsource, bus.retire} !== 4'b1101) begin
            n_errors++;
            $display("FAIL j_id: got %b expected 1101",
              {bus.pcwrite, bus.pcsource, bus.retire});
          end
        end
      end
      if ((k == BEQ || k == BNE) && c == ifw + 2) begin
        n_checks++;
        if ({bus.state, bus.pcwrite, bus.pcsource, bus.retire} !==
            {3'b010, (k == BEQ) ? zin : !zin, 2'b01, 1'b1}) begin
          n_errors++;
          $display("FAIL br_exe k=%0d z=%0b: got %b expected %b",
            k, zin, {bus.state, bus.pcwrite, bus.pcsource, bus.retire},
            {3'b010, (k == BEQ) ? zin : !zin, 2'b01, 1'b1});
        end
      end
      if (bus.wreg) begin
        wreg_n++;
        wb_got = {bus.aluc, bus.regrt, bus.m2reg};
      end
      if (bus.wmem) wmem_n++;
      if (bus.pcwrite) pcw_n++;
      if (bus.mem_req && bus.iord) iord_n++;
      if (bus.retire) begin
        done = 1;
        ncyc = c + 1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (ncyc != exp_cyc) begin
      n_errors++;
      $display("FAIL cycles k=%0d ifw=%0d mw=%0d: got %0d expected %0d",
        k, ifw, mw, ncyc, exp_cyc);
    end
    n_checks++;
    if ({wreg_n, wmem_n, pcw_n, iord_n} !==
        {((k <= 9) || k == LW) ? 1 : 0,
         (k == SW) ? mw + 1 : 0, exp_pcw, exp_mem}) begin
      n_errors++;
      $display("FAIL counts k=%0d: got wreg=%0d wmem=%0d pcw=%0d mem=%0d expected wreg=%0d wmem=%0d pcw=%0d mem=%0d",
        k, wreg_n, wmem_n, pcw_n, iord_n,
        ((k <= 9) || k == LW) ? 1 : 0,
        (k == SW) ? mw + 1 : 0, exp_pcw, exp_mem);
    end
    if ((k <= 9) || k == LW) begin
      n_checks++;
      if (wb_got !== wb_exp) begin
        n_errors++;
        $display("FAIL wb_ctl k=%0d: got %b expected %b",
          k, wb_got, wb_exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] seq [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    rst = 1'b1;
    bus.op = 6'b000000;
    bus.func = 6'b000001;
    bus.z = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (outs() !== 21'd0) begin
        n_errors++;
        $display("FAIL rst_outs: got %h expected 0", outs());
      end
      @(negedge clk);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if ({bus.state, bus.retire} !== {seq[c], c == 3}) begin
        n_errors++;
        $display("FAIL rst_seq c=%0d: got %b expected %b",
          c, {bus.state, bus.retire}, {seq[c], c == 3});
      end
      if (c == 0) begin
        n_checks++;
        if ({bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite,
             bus.pcsource} !== 6'b101100) begin
          n_errors++;
          $display("FAIL rst_fetch: got %b expected 101100",
            {bus.mem_req, bus.iord, bus.irwrite, bus.pcwrite,
             bus.pcsource});
        end
      end
      if (c == 3) begin
        n_checks++;
        if ({bus.wreg, bus.regrt, bus.aluc} !== 5'b10000) begin
          n_errors++;
          $display("FAIL rst_wb: got %b expected 10000",
            {bus.wreg, bus.regrt, bus.aluc});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branches();
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);
    run_instr(BNE, 1'b1, 0, 0);
    run_instr(BNE, 1'b0, 2, 0);
  endtask

  task automatic test_load_wait();
    run_instr(LW, 1'b0, 0, 3);
    run_instr(LW, 1'b1, 14, 14);
  endtask

  task automatic test_store_jump();
    run_instr(SW, 1'b0, 0, 0);
    run_instr(SW, 1'b0, 1, 2);
    run_instr(JMP, 1'b0, 0, 0);
  endtask

  task automatic check_trap(input logic [5:0] o, input logic [5:0] f);
    bus.op = o;
    bus.func = f;
    bus.mem_ready = 1'b1;
    #1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.state, bus.pcwrite, bus.retire} !== 5'b00100) begin
      n_errors++;
      $display("FAIL trap_id op=%b: got %b expected 00100",
        o, {bus.state, bus.pcwrite, bus.retire});
    end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      bus.mem_ready = 1'($urandom);
      #1;
      n_checks++;
      if (outs() !== {16'd0, 3'b111, 1'b0, 1'b1}) begin
        n_errors++;
        $display("FAIL trap_hold op=%b: got %h expected %h",
          o, outs(), {16'd0, 3'b111, 1'b0, 1'b1});
      end
      @(negedge clk);
    end
    do_reset(2);
  endtask

  task automatic test_illegal();
    logic [5:0] o, f;
    int k;
    check_trap(6'b000001, 6'b000111);
    check_trap(6'b111111, 6'b000000);
    check_trap(6'b000000, 6'b111000);
    for (int i = 0; i < 10; i++) begin
      o = 6'($urandom);
      f = 6'($urandom);
      k = legal_ref(o, f);
      if (k < 0) check_trap(o, f);
      else run_instr(k, 1'($urandom), 0, 0);
    end
  endtask

  task automatic test_watchdog();
    int wn;
    bus.op = 6'b000000;
    bus.func = 6'b000001;
    bus.mem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      #1;
      if (c == 15) begin
        n_checks++;
        if ({bus.state, bus.mem_req} !== 4'b0001) begin
          n_errors++;
          $display("FAIL wd_if_last: got %b expected 0001",
            {bus.state, bus.mem_req});
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if ({bus.state, bus.illegal, bus.mem_req} !== 5'b11110) begin
      n_errors++;
      $display("FAIL wd_if_trap: got %b expected 11110",
        {bus.state, bus.illegal, bus.mem_req});
    end
    @(negedge clk);
    do_reset(2);
    wn = 0;
    bus.op = 6'b001110;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      #1;
      if (bus.wmem) wn++;
      if (c == 15) begin
        n_checks++;
        if ({bus.state, bus.wmem, bus.retire} !== 5'b01100) begin
          n_errors++;
          $display("FAIL wd_mem_last: got %b expected 01100",
            {bus.state, bus.wmem, bus.retire});
        end
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if ({wn, bus.state, bus.illegal} !== {32'd14, 3'b111, 1'b1}) begin
      n_errors++;
      $display("FAIL wd_mem_trap: got wmem=%0d st=%b ill=%b expected wmem=14 st=111 ill=1",
        wn, bus.state, bus.illegal);
    end
    @(negedge clk);
    do_reset(2);
  endtask

  task automatic test_reset_abort();
    bus.op = 6'b001101;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({bus.state, bus.mem_req, bus.iord} !== 5'b01111) begin
      n_errors++;
      $display("FAIL abort_mem: got %b expected 01111",
        {bus.state, bus.mem_req, bus.iord});
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 21'd0) begin
      n_errors++;
      $display("FAIL abort_async: got %h expected 0", outs());
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({bus.state, bus.mem_req, bus.iord, bus.wreg, bus.retire,
           bus.wmem, bus.pcwrite} !== 9'b000100000) begin
        n_errors++;
        $display("FAIL abort_refetch c=%0d: got %b expected 000100000",
          c, {bus.state, bus.mem_req, bus.iord, bus.wreg, bus.retire,
              bus.wmem, bus.pcwrite});
      end
      @(negedge clk);
    end
    run_instr(0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(0, 14)), 1'($urandom),
                int'($urandom_range(0, 14)),
                int'($urandom_range(0, 14)));
  endtask

  initial begin
    rst = 1'b1;
    bus.op = '0;
    bus.func = '0;
    bus.z = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_branches();
    test_load_wait();
    test_store_jump();
    test_illegal();
    test_watchdog();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
